// File: rtl/rv32i_pkg.sv
// Shared encodings for the RV32I core: opcodes, ALU op codes and the multicycle
// control state type.
package rv32i_pkg;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_L = 7'b0000011;

  // ALU op is {instr[30], funct3}
  localparam logic [3:0] ADD  = 4'b0000;
  localparam logic [3:0] SUB  = 4'b1000;
  localparam logic [3:0] SLL  = 4'b0001;
  localparam logic [3:0] SLT  = 4'b0010;
  localparam logic [3:0] SLTU = 4'b0011;
  localparam logic [3:0] XOR  = 4'b0100;
  localparam logic [3:0] SRL  = 4'b0101;
  localparam logic [3:0] SRA  = 4'b1101;
  localparam logic [3:0] OR   = 4'b0110;
  localparam logic [3:0] AND  = 4'b0111;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    R_EXE,
    I_EXE,
    S_EXE,
    S_MEM,
    L_EXE,
    L_MEM,
    L_WB
  } state_e;

  function automatic logic is_supported(input logic [6:0] opcode);
    return (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_S) || (opcode == OP_L);
  endfunction

endpackage

// File: rtl/rv32i_alu_decoder.sv
// Combinational ALU op decode from {opcode, funct3, instr[30]}.
module rv32i_alu_decoder
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       bit30,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ADD;
    case (opcode)
      OP_R: alu_control = {bit30, funct3};
      // bit30 is only an opcode modifier for srli/srai; elsewhere it is immediate
      OP_I: alu_control = (funct3 == 3'b101) ? {bit30, funct3} : {1'b0, funct3};
      default: alu_control = ADD;
    endcase
  end

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// Multicycle control FSM: sequences fetch, decode and execute/memory/writeback
// for R, I-ALU, lw and sw, driving the datapath enables and selects per state.
module rv32i_multicycle_ctrl
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_code,
  output logic        pc_en,
  output logic        ir_en,
  output logic        reg_wr_en,
  output logic        alu_src,
  output logic [3:0]  alu_control,
  output logic        ram_wr_en,
  output logic        rf_wd_src,
  output logic        illegal_instr,
  output logic        instr_done
);

  state_e     state_q, state_d;
  logic [6:0] opcode;
  logic [3:0] dec_alu_control;
  logic       unused_instr_bits;

  assign opcode            = instr_code[6:0];
  assign unused_instr_bits = ^{instr_code[31], instr_code[29:15], instr_code[11:7]};

  rv32i_alu_decoder u_alu_decoder (
    .opcode      (opcode),
    .funct3      (instr_code[14:12]),
    .bit30       (instr_code[30]),
    .alu_control (dec_alu_control)
  );

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_R:    state_d = R_EXE;
          OP_I:    state_d = I_EXE;
          OP_S:    state_d = S_EXE;
          OP_L:    state_d = L_EXE;
          default: state_d = FETCH;
        endcase
      end
      S_EXE:   state_d = S_MEM;
      L_EXE:   state_d = L_MEM;
      L_MEM:   state_d = L_WB;
      default: state_d = FETCH;
    endcase
  end

  // Outputs decode the current state; reset masks them so a half-finished
  // instruction cannot commit a register or memory write.
  always_comb begin
    pc_en         = 1'b0;
    ir_en         = 1'b0;
    reg_wr_en     = 1'b0;
    alu_src       = 1'b0;
    alu_control   = ADD;
    ram_wr_en     = 1'b0;
    rf_wd_src     = 1'b0;
    illegal_instr = 1'b0;
    instr_done    = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: ir_en = 1'b1;
        DECODE: begin
          if (!is_supported(opcode)) begin
            illegal_instr = 1'b1;
            pc_en         = 1'b1;
            instr_done    = 1'b1;
          end
        end
        R_EXE, I_EXE: begin
          alu_src     = (state_q == I_EXE);
          alu_control = dec_alu_control;
          reg_wr_en   = 1'b1;
          pc_en       = 1'b1;
          instr_done  = 1'b1;
        end
        S_EXE, L_EXE, L_MEM: alu_src = 1'b1;
        S_MEM: begin
          alu_src    = 1'b1;
          ram_wr_en  = 1'b1;
          pc_en      = 1'b1;
          instr_done = 1'b1;
        end
        L_WB: begin
          alu_src    = 1'b1;
          rf_wd_src  = 1'b1;
          reg_wr_en  = 1'b1;
          pc_en      = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Scoreboard bench: stimulus pushes the expected per-cycle control vector,
// a negedge monitor pops and compares against the DUT outputs.
module tb_rv32i_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_code;
  logic        pc_en, ir_en, reg_wr_en, alu_src, ram_wr_en, rf_wd_src;
  logic        illegal_instr, instr_done;
  logic [3:0]  alu_control;

  // {ir, pc, reg_wr, alu_src, alu_control[3:0], ram_wr, rf_wd, illegal, done}
  typedef struct {
    logic [12:0]  vec;
    logic [31:0]  ins;
    int unsigned  k;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_cycle  = 0;

  rv32i_multicycle_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .instr_code    (instr_code),
    .pc_en         (pc_en),
    .ir_en         (ir_en),
    .reg_wr_en     (reg_wr_en),
    .alu_src       (alu_src),
    .alu_control   (alu_control),
    .ram_wr_en     (ram_wr_en),
    .rf_wd_src     (rf_wd_src),
    .illegal_instr (illegal_instr),
    .instr_done    (instr_done)
  );

  always #5 clk = ~clk;

  // Instruction class from opcode: 0=R 1=I 2=S 3=L 4=illegal
  function automatic int unsigned cls_of(input logic [31:0] ins);
    case (ins[6:0])
      7'b0110011: return 0;
      7'b0010011: return 1;
      7'b0100011: return 2;
      7'b0000011: return 3;
      default:    return 4;
    endcase
  endfunction

  function automatic int unsigned lat_of(input logic [31:0] ins);
    int unsigned lat_tbl[5] = '{3, 3, 4, 5, 2};
    return lat_tbl[cls_of(ins)];
  endfunction

  // Expected outputs in cycle k (1 = FETCH) of an instruction.
  function automatic logic [12:0] exp_vec(input logic [31:0] ins, input int unsigned k);
    int unsigned c    = cls_of(ins);
    logic        last = (k == lat_of(ins));
    logic        exe  = (k >= 3);
    logic [2:0]  f3   = ins[14:12];
    logic [3:0]  aluc = 4'd0;
    logic        src  = exe && (c == 1 || c == 2 || c == 3);
    if (exe && c == 0) aluc = {ins[30], f3};
    if (exe && c == 1) aluc = (f3 == 3'd5) ? {ins[30], f3} : {1'b0, f3};
    return {k == 1, last, last && (c == 0 || c == 1 || c == 3), src, aluc,
            last && c == 2, last && c == 3, last && c == 4, last};
  endfunction

  task automatic push(input logic [12:0] v, input logic [31:0] ins, input int unsigned k);
    exp_t e;
    e.vec = v;
    e.ins = ins;
    e.k   = k;
    sb_q.push_back(e);
  endtask

  // reset_at = cycle index in which reset is raised for one cycle (0 = none)
  task automatic run_instr(input logic [31:0] ins, input int unsigned reset_at);
    int unsigned n = lat_of(ins);
    for (int unsigned k = 1; k <= n; k++) begin
      instr_code = (k == 1) ? $urandom : ins;
      if (k == reset_at) begin
        reset = 1'b1;
        push('0, ins, k);
        @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
      push(exp_vec(ins, k), ins, k);
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r  = $urandom;
    int unsigned c  = $urandom_range(0, 4);
    logic [6:0]  op;
    case (c)
      0: op = 7'b0110011;
      1: op = 7'b0010011;
      2: op = 7'b0100011;
      3: op = 7'b0000011;
      default: begin
        op = 7'($urandom);
        while (op == 7'b0110011 || op == 7'b0010011 || op == 7'b0100011 || op == 7'b0000011)
          op = 7'($urandom);
      end
    endcase
    return {r[31:7], op};
  endfunction

  always @(negedge clk) begin
    logic [12:0] act;
    exp_t        e;
    n_cycle++;
    act = {ir_en, pc_en, reg_wr_en, alu_src, alu_control, ram_wr_en, rf_wd_src,
           illegal_instr, instr_done};
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if (act === e.vec) n_pass++;
      else $display("FAIL ctrl_vec cyc=%0d instr=%h k=%0d got=%b want=%b (ir,pc,rw,src,aluc4,mw,wd,ill,done)",
                    n_cycle, e.ins, e.k, act, e.vec);
    end
  end

  initial begin
    logic [31:0] directed[7] = '{32'h00110233, 32'h403E5713, 32'h00417513,
                                 32'h00202423, 32'h00802403, 32'h0000007F,
                                 32'h00110233};
    reset      = 1'b1;
    instr_code = $urandom;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      instr_code = $urandom;
      push('0, 32'h0, 0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) run_instr(directed[i], 0);
    run_instr(32'h00802403, 4);
    run_instr(directed[6], 0);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ins = rand_instr();
      int unsigned ra  = ($urandom_range(0, 15) == 0) ? $urandom_range(1, lat_of(ins)) : 0;
      run_instr(ins, ra);
    end
    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain left=%0d want=0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
